tlb_ctrl: RTL and testbench
===========================

# tlb_ctrl

Controller that sequences the dual-port TLB RAM (`dp_ram`, `D_WIDTH` = `ENTRY_WIDTH`, `A_WIDTH` = `TLB_DEPTH`). Port A serves a fully pipelined translation lookup stream. Port B serves a maintenance FSM that handles fill, invalidate-by-VA and flush-all, plus an automatic flush after reset. The TLB is direct-mapped: index = `vaddr[PAGE_DEPTH +: TLB_DEPTH]`; tag = full VPN.

## Interface

Parameters:
- `TLB_DEPTH`, 10, log2 of entry count
- `PAGE_DEPTH`, 12, log2 of page size
- `ADDR_WIDTH`, 32, virtual/physical address width
- `TAG_WIDTH` (local) = `ADDR_WIDTH - PAGE_DEPTH`; `ENTRY_WIDTH` (local) = `2*TAG_WIDTH + 4`

Ports:
- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  synchronous, active-low reset
- `lk_valid` / `lk_ready`  in / out  1  lookup handshake
- `lk_vaddr`  in  `ADDR_WIDTH`  lookup virtual address
- `lk_acc`  in  2  access type: 00 read, 01 write, 10 exec, 11 illegal
- `rsp_valid`  out  1  lookup result strobe (no backpressure)
- `rsp_hit`, `rsp_fault`  out  1  entry valid with VPN match; permission violation
- `rsp_paddr`  out  `ADDR_WIDTH`  `{ppn, vaddr[PAGE_DEPTH-1:0]}`
- `mt_valid` / `mt_ready`  in / out  1  maintenance handshake
- `mt_op`  in  2  00 fill, 01 invalidate-VA, 10 flush-all, 11 reserved
- `mt_vaddr`, `mt_paddr`  in  `ADDR_WIDTH`  fill/invalidate operands (page offsets ignored)
- `mt_perm`  in  3  `{X,W,R}` for fill
- `mt_done`  out  1  one-cycle completion pulse
- `ram_addr_a`, `ram_addr_b`  out  `TLB_DEPTH`; `ram_rdata_a`, `ram_rdata_b`  in  `ENTRY_WIDTH`; `ram_wdata_b`  out  `ENTRY_WIDTH`; `ram_wr_b`  out  1

## Operation

- Entry layout, MSB to LSB: `{valid, X, W, R, vpn[TAG_WIDTH], ppn[TAG_WIDTH]}`. Port A is never written.
- RAM contract: 1-cycle registered read. Reading port A at the same edge port B writes the same address returns the old data (read-first).
- Lookup:
  - Accepted when `lk_valid & lk_ready`.
  - `ram_addr_a` = index of `lk_vaddr`, combinational.
  - Stage 1 registers vaddr and acc.
  - Compare: `hit` = valid & (vpn == vaddr VPN).
  - `fault` = hit & (acc==11 | !perm[acc]).
  - `rsp_paddr` = 0 on a miss.
- FSM states: RST_FLUSH, IDLE, INV_CMP, FLUSH, DONE.
  - `mt_ready` = 1 only in IDLE.
  - `lk_ready` = 0 in RST_FLUSH and FLUSH; 1 otherwise.
- Fill (IDLE, accept): writes `{1, perm, vpn, ppn}` to the index at the accept edge → DONE.
- Invalidate-VA:
  - At accept, `ram_addr_b` = index; read → INV_CMP.
  - If valid and VPN matches, write all-zero entry; else no write → DONE.
- Flush-all:
  - Accept → FLUSH.
  - Counter writes zero to index 0, 1, …, `2^TLB_DEPTH-1`, one per edge; after the last write → DONE.
- DONE: `mt_done`=1 for one cycle → IDLE.
- `mt_op`=11: accepted, no RAM write → DONE.
- RST_FLUSH: identical sweep to FLUSH, entered after reset, ends in IDLE with no `mt_done` pulse.
- Ordering:
  - A lookup accepted at the same edge as a port-B write to its index sees pre-write data.
  - A lookup accepted on any later edge sees post-write data.
  - Lookups already in the pipeline when a flush starts complete with pre-flush data.

## Timing

- Lookup latency: accepted at edge N → `rsp_valid` high in the cycle after edge N+1. Throughput is 1/cycle; back-to-back responses are contiguous.
- Fill: accepted at N, written at N, `mt_done` in the cycle after N+1. Next `mt_ready` after N+2.
- Invalidate: read at N, write (if any) at N+1, `mt_done` in the cycle after N+2.
- Flush: accepted at N, writes at N+1 … N+2^TLB_DEPTH, `mt_done` one cycle later.
- Reset (`rst`=0 at an edge):
  - All outputs go 0 and the pipeline is cleared; in-flight lookups produce no `rsp_valid`.
  - FSM → RST_FLUSH, sweep counter = 0.
  - The sweep begins at the first edge with `rst`=1.
  - Reset asserted mid-sweep or mid-op restarts the sweep from index 0.
- `ram_wr_b` is never asserted in IDLE without an accepted fill.

## Test plan

Run with `TLB_DEPTH`=4, `PAGE_DEPTH`=12, `ADDR_WIDTH`=32 unless noted.

- Reset, then count cycles → `lk_ready`/`mt_ready` stay 0 for 16 sweep writes (indices 0..15, `wdata`=0), no `mt_done`. A lookup of 0x0000_5000 then misses (`rsp_hit`=0, `rsp_paddr`=0).
- Fill VA 0x0000_3000 → PA 0x0ABC_D000, perm R|W; lookups of 0x0000_3123 with acc=00, 01, 10 → `rsp_paddr`=0x0ABC_D123, hit=1, fault=0, 0, 1, each 2 cycles after accept.
- Same fill; lookup 0x0001_3000 (same index 3, different VPN) → hit=0. Invalidate 0x0001_3000 → no write, entry survives. Invalidate 0x0000_3000 → hit=0 afterwards.
- Fill index 5 accepted at the same edge as a lookup of that VA → that lookup misses; a lookup on the next edge hits.
- Flush-all with 3 lookups in the pipeline → all 3 respond with old data; `lk_ready`=0 for exactly 16 cycles; `mt_done` one cycle after the last write; all subsequent lookups miss.
- Assert `rst`=0 at sweep index 7 of a flush → outputs 0, no `rsp_valid`, no `mt_done`; after release the sweep restarts at index 0.

Source files
------------

// File: rtl/tlb_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_ctrl -- sequencer for a direct-mapped, dual-port TLB RAM.
//
// Port A carries a fully pipelined lookup stream. A lookup is accepted at edge
// N and its response is registered at edge N+1.
// Port B belongs to a maintenance FSM that handles fill, invalidate-by-VA and
// flush-all. The FSM also sweeps the whole RAM to zero after every reset.
//
// Entry layout, MSB..LSB: {valid, X, W, R, vpn[TAG_WIDTH], ppn[TAG_WIDTH]}
// index = vaddr[PAGE_DEPTH +: TLB_DEPTH], tag = full VPN.
//
// Ports
//   clk, rst                   clock; synchronous active-low reset
//   lk_valid/lk_ready          lookup handshake
//   lk_vaddr, lk_acc           lookup VA; access type 00 R, 01 W, 10 X, 11 illegal
//   rsp_valid/hit/fault/paddr  registered lookup result (no backpressure)
//   mt_valid/mt_ready          maintenance handshake
//   mt_op                      00 fill, 01 invalidate-VA, 10 flush-all, 11 reserved
//   mt_vaddr/mt_paddr/mt_perm  fill/invalidate operands, perm = {X,W,R}
//   mt_done                    one-cycle completion pulse
//   ram_*                      dp_ram ports (1-cycle read, read-first, B writes)
// -----------------------------------------------------------------------------
module tlb_ctrl #(
  parameter int  TLB_DEPTH   = 10,
  parameter int  PAGE_DEPTH  = 12,
  parameter int  ADDR_WIDTH  = 32,
  localparam int TAG_WIDTH   = ADDR_WIDTH - PAGE_DEPTH,
  localparam int ENTRY_WIDTH = 2*TAG_WIDTH + 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lk_valid,
  output logic                   lk_ready,
  input  logic [ADDR_WIDTH-1:0]  lk_vaddr,
  input  logic [1:0]             lk_acc,
  output logic                   rsp_valid,
  output logic                   rsp_hit,
  output logic                   rsp_fault,
  output logic [ADDR_WIDTH-1:0]  rsp_paddr,
  input  logic                   mt_valid,
  output logic                   mt_ready,
  input  logic [1:0]             mt_op,
  input  logic [ADDR_WIDTH-1:0]  mt_vaddr,
  input  logic [ADDR_WIDTH-1:0]  mt_paddr,
  input  logic [2:0]             mt_perm,
  output logic                   mt_done,
  output logic [TLB_DEPTH-1:0]   ram_addr_a,
  input  logic [ENTRY_WIDTH-1:0] ram_rdata_a,
  output logic [TLB_DEPTH-1:0]   ram_addr_b,
  input  logic [ENTRY_WIDTH-1:0] ram_rdata_b,
  output logic [ENTRY_WIDTH-1:0] ram_wdata_b,
  output logic                   ram_wr_b
);

  typedef enum logic [2:0] {RST_FLUSH, IDLE, INV_CMP, FLUSH, DONE} state_t;

  // ---------------------------------------------------------------------------
  // Lookup pipeline (port A)
  // ---------------------------------------------------------------------------
  logic                  r_lk_ready;
  logic                  r_s1_valid;
  logic [ADDR_WIDTH-1:0] r_s1_vaddr;
  logic [1:0]            r_s1_acc;
  logic                  r_rsp_valid, r_rsp_hit, r_rsp_fault;
  logic [ADDR_WIDTH-1:0] r_rsp_paddr;

  logic                  w_lk_fire;
  logic                  w_e_valid;
  logic [2:0]            w_e_perm;
  logic [TAG_WIDTH-1:0]  w_e_vpn, w_e_ppn;
  logic                  w_lk_hit;
  logic                  w_perm_ok;

  assign w_lk_fire  = lk_valid & r_lk_ready;
  assign ram_addr_a = lk_vaddr[PAGE_DEPTH +: TLB_DEPTH];

  assign w_e_valid = ram_rdata_a[ENTRY_WIDTH-1];
  assign w_e_perm  = ram_rdata_a[ENTRY_WIDTH-2 -: 3];
  assign w_e_vpn   = ram_rdata_a[TAG_WIDTH +: TAG_WIDTH];
  assign w_e_ppn   = ram_rdata_a[0 +: TAG_WIDTH];
  assign w_lk_hit  = r_s1_valid & w_e_valid &
                     (w_e_vpn == r_s1_vaddr[ADDR_WIDTH-1:PAGE_DEPTH]);

  // NOTE: give every always_comb output a default first so no path can leave it
  // unassigned, which would infer a latch.
  always_comb begin
    w_perm_ok = 1'b0;
    case (r_s1_acc)
      2'b00:   w_perm_ok = w_e_perm[0];
      2'b01:   w_perm_ok = w_e_perm[1];
      2'b10:   w_perm_ok = w_e_perm[2];
      default: w_perm_ok = 1'b0;      // illegal access type always faults
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_vaddr  <= '0;
      r_s1_acc    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_paddr <= '0;
    end else begin
      r_s1_valid <= w_lk_fire;
      if (w_lk_fire) begin
        r_s1_vaddr <= lk_vaddr;
        r_s1_acc   <= lk_acc;
      end
      r_rsp_valid <= r_s1_valid;
      r_rsp_hit   <= w_lk_hit;
      r_rsp_fault <= w_lk_hit & ~w_perm_ok;
      r_rsp_paddr <= w_lk_hit ? {w_e_ppn, r_s1_vaddr[PAGE_DEPTH-1:0]} : '0;
    end
  end

  assign lk_ready  = r_lk_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_fault = r_rsp_fault;
  assign rsp_paddr = r_rsp_paddr;

  // ---------------------------------------------------------------------------
  // Maintenance FSM (port B)
  // ---------------------------------------------------------------------------
  state_t               r_state;
  logic [TLB_DEPTH-1:0] r_cnt;
  logic [TAG_WIDTH-1:0] r_inv_vpn;
  logic                 r_mt_ready, r_mt_done;

  logic                 w_mt_fire;
  logic [TAG_WIDTH-1:0] w_mt_vpn, w_mt_ppn;
  logic                 w_inv_match;
  logic                 w_unused;

  assign w_mt_fire   = mt_valid & r_mt_ready;
  assign w_mt_vpn    = mt_vaddr[ADDR_WIDTH-1:PAGE_DEPTH];
  assign w_mt_ppn    = mt_paddr[ADDR_WIDTH-1:PAGE_DEPTH];
  assign w_inv_match = ram_rdata_b[ENTRY_WIDTH-1] &
                       (ram_rdata_b[TAG_WIDTH +: TAG_WIDTH] == r_inv_vpn);
  assign w_unused    = &{1'b0, mt_vaddr[PAGE_DEPTH-1:0], mt_paddr[PAGE_DEPTH-1:0],
                         ram_rdata_b[ENTRY_WIDTH-2 -: 3], ram_rdata_b[TAG_WIDTH-1:0]};

  // Port B drive. A fill writes at its own accept edge, so this path is
  // combinational. Gating with rst keeps the RAM untouched while reset is
  // held. The sweep's first write then lands on the first edge with rst high.
  always_comb begin
    ram_addr_b  = mt_vaddr[PAGE_DEPTH +: TLB_DEPTH];
    ram_wdata_b = '0;
    ram_wr_b    = 1'b0;
    case (r_state)
      RST_FLUSH, FLUSH: begin
        ram_addr_b = r_cnt;
        ram_wr_b   = rst;
      end
      INV_CMP: begin
        ram_addr_b = r_inv_vpn[TLB_DEPTH-1:0];
        ram_wr_b   = rst & w_inv_match;
      end
      IDLE: begin
        if (w_mt_fire && mt_op == 2'b00) begin
          ram_wr_b    = rst;
          ram_wdata_b = {1'b1, mt_perm, w_mt_vpn, w_mt_ppn};
        end
      end
      default: ;
    endcase
  end

  // The RAM itself has no reset. Stale entries are cleared by the RST_FLUSH
  // sweep, which restarts from index 0 on every reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= RST_FLUSH;
      r_cnt      <= '0;
      r_inv_vpn  <= '0;
      r_lk_ready <= 1'b0;
      r_mt_ready <= 1'b0;
      r_mt_done  <= 1'b0;
    end else begin
      r_mt_done <= 1'b0;
      case (r_state)
        RST_FLUSH, FLUSH: begin
          r_cnt <= r_cnt + 1'b1;               // wraps to 0 after the last index
          if (&r_cnt) begin
            r_lk_ready <= 1'b1;
            r_state    <= (r_state == FLUSH) ? DONE : IDLE;
          end
        end
        IDLE: begin
          // mt_ready rises one cycle after IDLE is entered and drops at accept.
          r_mt_ready <= 1'b1;
          if (w_mt_fire) begin
            r_mt_ready <= 1'b0;
            r_inv_vpn  <= w_mt_vpn;
            case (mt_op)
              2'b01:   r_state <= INV_CMP;
              2'b10: begin
                r_state    <= FLUSH;
                r_lk_ready <= 1'b0;
              end
              default: r_state <= DONE;        // fill (already written) or reserved
            endcase
          end
        end
        INV_CMP: r_state <= DONE;
        DONE: begin
          r_mt_done <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= RST_FLUSH;
      endcase
    end
  end

  assign mt_ready = r_mt_ready;
  assign mt_done  = r_mt_done;

endmodule

// File: tb/tb_tlb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tlb_ctrl -- self-checking bench for tlb_ctrl (TLB_DEPTH=4).
//
// The bench contains a behavioural dp_ram and a functional model of the TLB
// contents. Lookup expectations are pushed to a queue when a lookup is
// accepted. They are popped and compared when rsp_valid appears.
// -----------------------------------------------------------------------------
module tb_tlb_ctrl;

  localparam int TD = 4;
  localparam int PD = 12;
  localparam int AW = 32;
  localparam int TW = AW - PD;
  localparam int EW = 2*TW + 4;

  logic          clk;
  logic          rst;
  logic          lk_valid, lk_ready;
  logic [AW-1:0] lk_vaddr;
  logic [1:0]    lk_acc;
  logic          rsp_valid, rsp_hit, rsp_fault;
  logic [AW-1:0] rsp_paddr;
  logic          mt_valid, mt_ready;
  logic [1:0]    mt_op;
  logic [AW-1:0] mt_vaddr, mt_paddr;
  logic [2:0]    mt_perm;
  logic          mt_done;
  logic [TD-1:0] ram_addr_a, ram_addr_b;
  logic [EW-1:0] ram_rdata_a, ram_rdata_b, ram_wdata_b;
  logic          ram_wr_b;

  tlb_ctrl #(.TLB_DEPTH(TD), .PAGE_DEPTH(PD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_vaddr(lk_vaddr), .lk_acc(lk_acc),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_fault(rsp_fault), .rsp_paddr(rsp_paddr),
    .mt_valid(mt_valid), .mt_ready(mt_ready), .mt_op(mt_op),
    .mt_vaddr(mt_vaddr), .mt_paddr(mt_paddr), .mt_perm(mt_perm), .mt_done(mt_done),
    .ram_addr_a(ram_addr_a), .ram_rdata_a(ram_rdata_a),
    .ram_addr_b(ram_addr_b), .ram_rdata_b(ram_rdata_b),
    .ram_wdata_b(ram_wdata_b), .ram_wr_b(ram_wr_b)
  );

  // Behavioural dp_ram: registered read on both ports, read-first, B writes.
  logic [EW-1:0] mem [1<<TD];
  always @(posedge clk) begin
    ram_rdata_a <= mem[ram_addr_a];
    ram_rdata_b <= mem[ram_addr_b];
    if (ram_wr_b) mem[ram_addr_b] <= ram_wdata_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Model, scoreboard and checking
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          v;
    logic [2:0]    perm;
    logic [TW-1:0] vpn;
    logic [TW-1:0] ppn;
  } ent_t;

  typedef struct {
    logic          hit;
    logic          fault;
    logic [AW-1:0] paddr;
    int            cyc;
  } exp_t;

  ent_t tab [1<<TD];
  exp_t q [$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t predict(input logic [AW-1:0] va, input logic [1:0] acc);
    exp_t r;
    ent_t e;
    logic [3:0] p4;
    e       = tab[va[PD +: TD]];
    p4      = {1'b0, e.perm};                       // index 3 (illegal) reads 0
    r.hit   = e.v && (e.vpn == va[AW-1:PD]);
    r.fault = r.hit && !p4[acc];
    r.paddr = r.hit ? {e.ppn, va[PD-1:0]} : '0;
    r.cyc   = 0;
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < (1<<TD); i++) tab[i] = '{1'b0, 3'b000, '0, '0};
  endtask

  // Response monitor: compare away from the active edge.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check("rsp_latency", cyc, mon_e.cyc);
        check("rsp_hit", rsp_hit, mon_e.hit);
        check("rsp_fault", rsp_fault, mon_e.fault);
        check("rsp_paddr", rsp_paddr, mon_e.paddr);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input exp_t e);
    exp_t x;
    x     = e;
    x.cyc = cyc + 1;           // response is visible in the cycle after the next edge
    q.push_back(x);
  endtask

  task automatic wait_lk_ready();
    int n = 0;
    while (!lk_ready && n < 100) begin tick(); n++; end
    if (n == 100) check("lk_ready_timeout", 0, 1);
  endtask

  task automatic wait_mt_ready();
    int n = 0;
    while (!mt_ready && n < 100) begin tick(); n++; end
    if (n == 100) check("mt_ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic [AW-1:0] va, input logic [1:0] acc);
    exp_t e;
    wait_lk_ready();
    lk_valid = 1'b1; lk_vaddr = va; lk_acc = acc;
    e = predict(va, acc);
    tick();
    push_exp(e);
    lk_valid = 1'b0;
  endtask

  task automatic fill(input logic [AW-1:0] va, input logic [AW-1:0] pa, input logic [2:0] perm);
    logic [EW-1:0] ent;
    ent = {1'b1, perm, va[AW-1:PD], pa[AW-1:PD]};
    wait_mt_ready();
    mt_valid = 1'b1; mt_op = 2'b00; mt_vaddr = va; mt_paddr = pa; mt_perm = perm;
    #1;
    check("fill_wr", ram_wr_b, 1);
    check("fill_wdata", ram_wdata_b, ent);
    tick();
    mt_valid = 1'b0;
    tab[va[PD +: TD]] = '{1'b1, perm, va[AW-1:PD], pa[AW-1:PD]};
    check("fill_done_early", mt_done, 0);
    tick();
    check("fill_done", mt_done, 1);
    tick();
    check("fill_done_end", mt_done, 0);
  endtask

  task automatic inval(input logic [AW-1:0] va);
    ent_t e;
    logic exp_wr;
    e      = tab[va[PD +: TD]];
    exp_wr = e.v && (e.vpn == va[AW-1:PD]);
    wait_mt_ready();
    mt_valid = 1'b1; mt_op = 2'b01; mt_vaddr = va;
    tick();
    mt_valid = 1'b0;
    check("inv_wr", ram_wr_b, exp_wr);
    if (exp_wr) begin
      check("inv_addr", ram_addr_b, va[PD +: TD]);
      check("inv_wdata", ram_wdata_b, 0);
    end
    tick();
    if (exp_wr) tab[va[PD +: TD]].v = 1'b0;
    check("inv_done_early", mt_done, 0);
    tick();
    check("inv_done", mt_done, 1);
  endtask

  // Walks a sweep that is already in progress. It expects 16 cycles with
  // lk_ready low, each writing zero to the next index from 0 upward, and no
  // mt_ready or mt_done in between.
  task automatic sweep_check(input string tag);
    int n = 0, wr_ok = 0, side = 0;
    while (!lk_ready && n < 40) begin
      if (ram_wr_b && ram_addr_b == 4'(n) && ram_wdata_b == '0) wr_ok++;
      if (mt_ready || mt_done) side++;
      n++;
      tick();
    end
    check({tag, "_len"}, n, 16);
    check({tag, "_writes"}, wr_ok, 16);
    check({tag, "_side"}, side, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_lk_ready"}, lk_ready, 0);
    check({tag, "_mt_ready"}, mt_ready, 0);
    check({tag, "_mt_done"}, mt_done, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_ram_wr"}, ram_wr_b, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    int   n;
    int   dones;

    // Garbage RAM, plus an entry that would hit 0x0000_5000 if it survived the sweep.
    for (int i = 0; i < (1<<TD); i++) mem[i] = EW'({$urandom(), $urandom()});
    mem[5] = {1'b1, 3'b111, 20'h00005, 20'h12345};
    clear_model();

    rst = 1'b0;
    lk_valid = 1'b0; lk_vaddr = '0; lk_acc = '0;
    mt_valid = 1'b0; mt_op = '0; mt_vaddr = '0; mt_paddr = '0; mt_perm = '0;

    // Reset and post-reset sweep.
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b1;
    #1;
    sweep_check("rst_sweep");
    tick();
    check("rst_mt_ready", mt_ready, 1);
    check("rst_no_done", mt_done, 0);
    issue(32'h0000_5000, 2'b00);                     // miss

    // Fill and permission checks, with back-to-back lookups.
    fill(32'h0000_3000, 32'h0ABC_D000, 3'b011);
    issue(32'h0000_3123, 2'b00);
    issue(32'h0000_3123, 2'b01);
    issue(32'h0000_3123, 2'b10);
    issue(32'h0000_3123, 2'b11);

    // Same index, different VPN.
    issue(32'h0001_3000, 2'b00);
    inval(32'h0001_3000);                            // no write
    issue(32'h0000_3123, 2'b00);                     // still hits
    inval(32'h0000_3000);                            // clears
    issue(32'h0000_3123, 2'b00);                     // miss

    // Fill of index 5 at the same edge as a lookup of that VA.
    wait_mt_ready();
    wait_lk_ready();
    mt_valid = 1'b1; mt_op = 2'b00; mt_vaddr = 32'h0000_5000;
    mt_paddr = 32'h0000_7000; mt_perm = 3'b111;
    lk_valid = 1'b1; lk_vaddr = 32'h0000_5000; lk_acc = 2'b00;
    e = predict(32'h0000_5000, 2'b00);               // pre-write view: miss
    tick();
    push_exp(e);
    tab[5] = '{1'b1, 3'b111, 20'h00005, 20'h00007};
    mt_valid = 1'b0;
    issue(32'h0000_5000, 2'b00);                     // next edge: hit
    check("same_edge_fill_done", mt_done, 1);

    fill(32'h0000_9000, 32'h0011_1000, 3'b100);

    // Flush-all with three lookups in the pipeline.
    wait_mt_ready();
    issue(32'h0000_5010, 2'b00);
    issue(32'h0000_9ABC, 2'b10);
    lk_valid = 1'b1; lk_vaddr = 32'h0000_5FFF; lk_acc = 2'b01;
    mt_valid = 1'b1; mt_op = 2'b10;
    e = predict(32'h0000_5FFF, 2'b01);
    tick();
    push_exp(e);
    lk_valid = 1'b0; mt_valid = 1'b0;
    sweep_check("flush");
    clear_model();
    check("flush_done_early", mt_done, 0);
    tick();
    check("flush_done", mt_done, 1);
    tick();
    check("flush_done_end", mt_done, 0);
    issue(32'h0000_5010, 2'b00);
    issue(32'h0000_9ABC, 2'b10);

    // Reset with a lookup in flight: no response may appear.
    repeat (3) tick();
    fill(32'h0000_A000, 32'h0022_2000, 3'b001);
    issue(32'h0000_A000, 2'b00);
    rst = 1'b0;
    q.delete();
    tick();
    check_outputs_zero("rst_inflight");
    tick();
    rst = 1'b1;
    #1;
    sweep_check("rst2_sweep");
    clear_model();

    // Reset at sweep index 7 of a flush.
    fill(32'h0000_B000, 32'h0033_3000, 3'b001);
    wait_mt_ready();
    mt_valid = 1'b1; mt_op = 2'b10;
    tick();
    mt_valid = 1'b0;
    n = 0;
    while (!(ram_wr_b && ram_addr_b == 4'd7) && n < 40) begin tick(); n++; end
    check("midsweep_reached7", ram_addr_b, 7);
    rst = 1'b0;
    tick();
    check_outputs_zero("midsweep_rst");
    tick();
    check_outputs_zero("midsweep_hold");
    rst = 1'b1;
    #1;
    sweep_check("midsweep_restart");
    clear_model();
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (mt_done) dones++;
      tick();
    end
    check("midsweep_no_done", dones, 0);
    issue(32'h0000_B000, 2'b00);                     // swept: miss

    // Drain and finish.
    repeat (5) tick();
    check("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
